key_select_ctrl: RTL and testbench
==================================

Name: key_select_ctrl

Overview:
- Upstream stage for the 2-to-4 LED decoder on the EP4CE6 kit.
- Synchronizes and debounces the four raw active-low push-buttons, and produces one-cycle press/release pulses.
- Maintains a registered 2-bit selection and an override flag, both driven by button presses.
- Presents them as a 4-bit word in exactly the format the decoder's KEY input expects.

Parameters:
- DB_CYCLES, 1000000, consecutive stable clock cycles required to accept a new key level (20 ms at 50 MHz). Legal range ≥2.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RST  input  1  reset: synchronous, active-high.
- KEY  input  4  raw push-buttons, active-low (0 = pressed), asynchronous to CLK.
- PRESSED  output  4  debounced level, active-high (1 = held).
- PRESS  output  4  one-cycle pulse on each debounced press.
- RELEASE  output  4  one-cycle pulse on each debounced release.
- SEL  output  2  current selection.
- OVR  output  1  override flag.
- DEC_KEY  output  4  decoder drive word: {1'b1, ~OVR, SEL[1:0]}.

Behaviour:
- Single clock domain (CLK). All state updates on the rising edge of CLK.
- Reset: RST is synchronous, active-high.
  - Synchronizer flops reset to 1 (released).
  - Debounce counters reset to 0 and stable levels to released.
  - PRESSED = 0, PRESS = 0, RELEASE = 0, SEL = 0, OVR = 0, DEC_KEY = 4'b1100.
- Synchronizer: 2-flop chain per key, giving ksync[i].
- Debounce, per key i, with stable[i] as the accepted raw level:
  - If ksync[i] == stable[i]: counter is set to 0.
  - Else if counter == DB_CYCLES-1: stable[i] takes ksync[i] and counter is set to 0.
  - Else: counter increments.
  - Any bounce back to the stable level restarts the count.
  - Counter never exceeds DB_CYCLES-1; no wrap.
- PRESSED[i] = ~stable[i], registered.
- Latency: a clean raw edge changes PRESSED 2 + DB_CYCLES cycles later (±1 for input sampling).
- Pulses:
  - PRESS[i] is high for exactly the one cycle in which PRESSED[i] rises.
  - RELEASE[i] is high for exactly the one cycle in which PRESSED[i] falls.
  - Never asserted during or in the cycle after reset.
- Selection logic, evaluated on PRESS in the same cycle; SEL/OVR update on the following edge:
  - PRESS[3] (clear): SEL <= 0. Highest priority; overrides PRESS[0]/PRESS[1].
  - PRESS[0] only: SEL <= SEL+1, wrapping 3→0.
  - PRESS[1] only: SEL <= SEL-1, wrapping 0→3.
  - PRESS[0] and PRESS[1] together: SEL unchanged.
  - PRESS[2]: OVR <= ~OVR. Independent of SEL actions; may coincide with them.
- DEC_KEY is combinational from the SEL/OVR registers; no additional latency.
  - DEC_KEY[2] low means the decoder's override (all LEDs on) is active.
- Held key: produces one PRESS only; no auto-repeat.
- Reset mid-debounce: partial counts are discarded. After RST deasserts, a key still held must re-qualify: 2 + DB_CYCLES cycles, then PRESS.
- RST asserted in the same cycle as a PRESS: reset wins.

Test Plan (DB_CYCLES=4, CNT_W=3 for simulation):
1. Reset and idle:
   - Stimulus: RST=1 for 3 cycles with KEY=4'b1111, then release RST and idle 20 cycles.
   - Required: PRESSED=0, PRESS=0, RELEASE=0, SEL=0, OVR=0, DEC_KEY=4'b1100 throughout.
2. Clean press:
   - Stimulus: KEY[0]=0 held for 30 cycles.
   - Required: PRESSED[0] rises 6±1 cycles after the edge; PRESS[0] is high for exactly 1 cycle.
   - Required: next cycle SEL=1, DEC_KEY=4'b1101. Release gives exactly one RELEASE[0] and no SEL change.
3. Bounce rejection:
   - Stimulus: KEY[1] toggles 0/1 every 2 cycles for 20 cycles, then is held 0.
   - Required: no PRESS during toggling; exactly one PRESS[1] after the hold.
   - Required: with SEL=0 beforehand, SEL becomes 3 (wrap down).
4. Wrap and clear:
   - Stimulus: four separate KEY[0] presses.
   - Required: SEL steps 1, 2, 3, 0.
   - Stimulus: press KEY[0] and KEY[3] so their PRESS pulses coincide.
   - Required: SEL=0.
   - Stimulus: press KEY[0] and KEY[1] simultaneously from SEL=2.
   - Required: SEL stays 2.
5. Override toggle:
   - Stimulus: press KEY[2] twice.
   - Required: OVR goes 1 (DEC_KEY[2]=0), then back to 0. SEL is unaffected.
6. Reset mid-debounce:
   - Stimulus: hold KEY[0]=0; pulse RST for 1 cycle at 3 cycles after the edge.
   - Required: no PRESS before reset completes; exactly one PRESS[0] 6±1 cycles after RST deasserts.
   - Required: SEL=1 afterwards (it was 0 from reset).

Source files
------------

// File: rtl/key_select_ctrl.sv
// key_select_ctrl: synchronizes and debounces four active-low push-buttons,
// turns debounced edges into one-cycle press/release pulses, and keeps the
// 2-bit selection plus override flag that drive the 2-to-4 LED decoder.

// Per-key debouncer: accepts a new level only after DB_CYCLES consecutive
// cycles of the synchronized input disagreeing with the current stable level.
module key_select_lane #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic ksync,
    output logic stable
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Count disagreement; any return to the stable level restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (ksync == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = ksync;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and accepted level; reset to released (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
endmodule

module key_select_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY,
    output logic [3:0] PRESSED,
    output logic [3:0] PRESS,
    output logic [3:0] RELEASE,
    output logic [1:0] SEL,
    output logic       OVR,
    output logic [3:0] DEC_KEY
);
    logic [3:0] ks1_q, ks1_d;
    logic [3:0] ks2_q, ks2_d;
    logic [3:0] stable;
    logic [3:0] pressed_q, pressed_d;
    logic [3:0] press_q, press_d;
    logic [3:0] release_q, release_d;
    logic [1:0] sel_q, sel_d;
    logic       ovr_q, ovr_d;

    // Two-flop synchronizer chain, idle level is released (high).
    always_comb begin
        ks1_d = KEY;
        ks2_d = ks1_q;
    end

    // One debouncer per key.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        key_select_lane #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk   (CLK),
            .rst   (RST),
            .ksync (ks2_q[i]),
            .stable(stable[i])
        );
    end

    // Registered level and edge pulses; a pulse lines up with the cycle the
    // registered level changes.
    always_comb begin
        pressed_d = ~stable;
        press_d   = ~stable & ~pressed_q;
        release_d = stable & pressed_q;
    end

    // Selection/override update from this cycle's press pulses; clear wins,
    // opposing step presses cancel, override toggles independently.
    always_comb begin
        sel_d = sel_q;
        ovr_d = ovr_q;
        if (press_q[3]) begin
            sel_d = 2'd0;
        end else if (press_q[0] && !press_q[1]) begin
            sel_d = sel_q + 2'd1;
        end else if (press_q[1] && !press_q[0]) begin
            sel_d = sel_q - 2'd1;
        end
        if (press_q[2]) begin
            ovr_d = ~ovr_q;
        end
    end

    // All state registers; reset takes precedence over any pending pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ks1_q     <= 4'hF;
            ks2_q     <= 4'hF;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            sel_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            ks1_q     <= ks1_d;
            ks2_q     <= ks2_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            sel_q     <= sel_d;
            ovr_q     <= ovr_d;
        end
    end

    assign PRESSED = pressed_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign SEL     = sel_q;
    assign OVR     = ovr_q;
    // Decoder word: bit 2 low turns the decoder's all-on override on.
    assign DEC_KEY = {1'b1, ~ovr_q, sel_q};
endmodule

// File: tb/tb_key_select_ctrl.sv
// Bench for key_select_ctrl: a history-window reference model checked every
// cycle, a table of press/expected-selection records, and hand sequences for
// latency, bounce and reset-mid-debounce corners.
module tb_key_select_ctrl;
    localparam int DB = 4;
    localparam int CW = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] KEY = 4'hF;
    logic [3:0] PRESSED, PRESS, RELEASE, DEC_KEY;
    logic [1:0] SEL;
    logic       OVR;

    key_select_ctrl #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .KEY(KEY), .PRESSED(PRESSED), .PRESS(PRESS),
        .RELEASE(RELEASE), .SEL(SEL), .OVR(OVR), .DEC_KEY(DEC_KEY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int press_cyc [4];

    // Reference model state.
    logic [3:0] m_k1, m_k2, m_st, m_pr, m_ps, m_rl;
    logic [1:0] m_sel;
    logic       m_ovr;
    logic [3:0] hist[$];

    typedef struct {
        logic [3:0] key;
        logic [1:0] sel;
        logic       ovr;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a key level is accepted once the last DB synchronized samples
    // since reset all disagree with the current accepted level.
    task automatic model_edge(input logic [3:0] k, input logic r);
        logic [3:0] nst;
        logic       all;
        logic [1:0] nsel;
        if (r) begin
            m_k1 = 4'hF; m_k2 = 4'hF; m_st = 4'hF;
            m_pr = '0; m_ps = '0; m_rl = '0; m_sel = '0; m_ovr = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_k2);
            if (hist.size() > DB) void'(hist.pop_front());
            nst = m_st;
            for (int i = 0; i < 4; i++) begin
                if (hist.size() == DB) begin
                    all = 1'b1;
                    for (int j = 0; j < hist.size(); j++)
                        if (hist[j][i] == m_st[i]) all = 1'b0;
                    if (all) nst[i] = ~m_st[i];
                end
            end
            nsel = m_sel;
            if (m_ps[3]) nsel = 2'd0;
            else if (m_ps[0] && !m_ps[1]) nsel = 2'((int'(m_sel) + 1) % 4);
            else if (m_ps[1] && !m_ps[0]) nsel = 2'((int'(m_sel) + 3) % 4);
            if (m_ps[2]) m_ovr = ~m_ovr;
            m_sel = nsel;
            m_ps  = ~m_st & ~m_pr;
            m_rl  = m_st & m_pr;
            m_pr  = ~m_st;
            m_st  = nst;
            m_k2  = m_k1;
            m_k1  = k;
        end
    endtask

    // One clock: drive, advance model on the edge, compare on the falling edge.
    task automatic step(input logic [3:0] k, input logic r);
        KEY = k;
        RST = r;
        @(posedge CLK);
        model_edge(k, r);
        cyc++;
        @(negedge CLK);
        check("outputs", {13'd0, PRESSED, PRESS, RELEASE, SEL, OVR, DEC_KEY},
              {13'd0, m_pr, m_ps, m_rl, m_sel, m_ovr, 1'b1, ~m_ovr, m_sel});
        for (int i = 0; i < 4; i++) begin
            if (PRESS[i] === 1'b1) begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (RELEASE[i] === 1'b1) rel_cnt[i]++;
        end
    endtask

    task automatic run(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; press_cyc[i] = -100;
        end
    endtask

    initial begin
        int c0, r_end;
        logic [3:0] rk;
        tbl[0]  = '{4'b1110, 2'd1, 1'b0};
        tbl[1]  = '{4'b1110, 2'd2, 1'b0};
        tbl[2]  = '{4'b1110, 2'd3, 1'b0};
        tbl[3]  = '{4'b1110, 2'd0, 1'b0};
        tbl[4]  = '{4'b1110, 2'd1, 1'b0};
        tbl[5]  = '{4'b0110, 2'd0, 1'b0};  // step + clear together: clear wins
        tbl[6]  = '{4'b1110, 2'd1, 1'b0};
        tbl[7]  = '{4'b1110, 2'd2, 1'b0};
        tbl[8]  = '{4'b1100, 2'd2, 1'b0};  // up + down together: no change
        tbl[9]  = '{4'b1011, 2'd2, 1'b1};
        tbl[10] = '{4'b1011, 2'd2, 1'b0};
        tbl[11] = '{4'b1101, 2'd1, 1'b0};
        tbl[12] = '{4'b1010, 2'd2, 1'b1};  // step and override together
        clr_counts();

        // Reset and idle.
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        check("reset_dec", {28'd0, DEC_KEY}, 32'hC);
        run(4'hF, 20);
        check("idle_sel", {30'd0, SEL}, 0);
        check("idle_dec", {28'd0, DEC_KEY}, 32'hC);
        check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // Clean press of KEY[0] then release.
        clr_counts();
        c0 = cyc;
        run(4'b1110, 30);
        check("clean_press_cnt", press_cnt[0], 1);
        check("clean_latency_ok", (press_cyc[0] - c0 >= 5 && press_cyc[0] - c0 <= 7) ? 1 : 0, 1);
        check("clean_sel", {30'd0, SEL}, 1);
        check("clean_dec", {28'd0, DEC_KEY}, 32'hD);
        run(4'hF, 15);
        check("clean_rel_cnt", rel_cnt[0], 1);
        check("clean_sel_after_rel", {30'd0, SEL}, 1);

        // Bounce rejection on KEY[1] from SEL=0.
        step(4'hF, 1'b1);
        clr_counts();
        for (int i = 0; i < 5; i++) begin
            run(4'b1101, 2);
            run(4'b1111, 2);
        end
        check("bounce_no_press", press_cnt[1], 0);
        run(4'b1101, 15);
        check("bounce_one_press", press_cnt[1], 1);
        check("bounce_sel_wrap", {30'd0, SEL}, 3);
        run(4'hF, 15);

        // Table-driven press sequence from reset.
        step(4'hF, 1'b1);
        for (int t = 0; t < 13; t++) begin
            run(tbl[t].key, 10);
            run(4'hF, 10);
            check($sformatf("tbl%0d_sel", t), {30'd0, SEL}, {30'd0, tbl[t].sel});
            check($sformatf("tbl%0d_ovr", t), {31'd0, OVR}, {31'd0, tbl[t].ovr});
            check($sformatf("tbl%0d_dec", t), {28'd0, DEC_KEY},
                  {28'd0, 1'b1, ~tbl[t].ovr, tbl[t].sel});
        end

        // Reset in the middle of a debounce.
        step(4'hF, 1'b1);
        run(4'hF, 3);
        clr_counts();
        run(4'b1110, 3);
        step(4'b1110, 1'b1);
        r_end = cyc;
        check("mid_rst_no_early", press_cnt[0], 0);
        run(4'b1110, 20);
        check("mid_rst_one_press", press_cnt[0], 1);
        check("mid_rst_latency_ok",
              (press_cyc[0] - r_end >= 5 && press_cyc[0] - r_end <= 7) ? 1 : 0, 1);
        check("mid_rst_sel", {30'd0, SEL}, 1);
        run(4'hF, 10);

        // Random keys with occasional reset, checked against the model.
        rk = 4'hF;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) rk[b] = ~rk[b];
            step(rk, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
